// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared FSM state type and saturating increment for the period meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    // Wide enough for any supported counter width; callers truncate the value back.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic [SAT_W-1:0] val;
        logic             sat;
    } sat_t;

    function automatic sat_t sat_inc(input logic [SAT_W-1:0] cnt, input logic [SAT_W-1:0] max_val);
        sat_t r;
        r.sat = (cnt >= max_val);
        r.val = r.sat ? max_val : cnt + SAT_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_hyst.sv
// rtl/freq_meter_hyst.sv - registered hysteresis comparator with rising-edge detect.
module freq_meter_hyst #(
    parameter int WD = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WD-1:0] sample,
    input  logic [WD-1:0] threshold,
    output logic          q,
    output logic          rise
);

    logic              prev_q;
    logic signed [WD:0] d;
    logic signed [WD:0] hi;
    logic signed [WD:0] lo;

    // One extra bit so the threshold is a non-negative magnitude and -thr never overflows.
    assign d  = {sample[WD-1], sample};
    assign hi = {1'b0, threshold};
    assign lo = -hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            if (d > hi) begin
                q <= 1'b1;
            end else if (d < lo) begin
                q <= 1'b0;
            end
            prev_q <= q;
        end
    end

    assign rise = q & ~prev_q;

endmodule

// File: rtl/freq_meter_mc.sv
// rtl/freq_meter_mc.sv - multi-channel averaging period meter.
// Optional timeout response enabled by defining FREQ_METER_TIMEOUT_EN.
module freq_meter_mc
    import freq_meter_pkg::*;
#(
    parameter int WD       = 14,
    parameter int CH       = 2,
    parameter int CW       = 32,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 2**24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*WD-1:0] signal_in,
    input  logic [WD-1:0]    threshold,
    input  logic [CH-1:0]    ch_en,
    output logic [CH*CW-1:0] period_out,
    output logic [CH-1:0]    period_valid,
    output logic [CH-1:0]    ovf,
    output logic [CH-1:0]    timeout
);

    localparam int                AW      = CW + AVG_LOG2;
    localparam logic [AVG_LOG2:0] NAVG    = (AVG_LOG2+1)'(2**AVG_LOG2);
    localparam logic [CW-1:0]     CNT_MAX = '1;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic              en;
        logic              q;
        logic              rise;
        state_t            state;
        state_t            state_next;
        logic [CW-1:0]     cnt;
        logic [CW-1:0]     smp;
        logic [CW-1:0]     per_q;
        logic [AW-1:0]     acc;
        logic [AW-1:0]     acc_next;
        logic [AW-1:0]     acc_shr;
        logic [AVG_LOG2:0] nsmp;
        logic [AVG_LOG2:0] nsmp_next;
        logic              sat_flag;
        logic              flag_next;
        logic              valid_q;
        logic              ovf_q;
        logic              to_q;
        sat_t              inc;
        logic              do_arm;
        logic              do_sample;
        logic              do_result;
        logic              do_timeout;
        logic              meas_to;
        logic              arm_to;
        logic              unused_bits;

        assign en = ch_en[k];

        freq_meter_hyst #(.WD(WD)) u_hyst (
            .clk       (clk),
            .rst       (rst),
            .sample    (signal_in[k*WD +: WD]),
            .threshold (threshold),
            .q         (q),
            .rise      (rise)
        );

        always_comb inc = sat_inc(SAT_W'(cnt), SAT_W'(CNT_MAX));

        assign smp       = inc.val[CW-1:0];
        assign acc_next  = acc + AW'(smp);
        assign acc_shr   = acc_next >> AVG_LOG2;
        assign nsmp_next = nsmp + (AVG_LOG2+1)'(1);
        assign flag_next = sat_flag | inc.sat;

`ifdef FREQ_METER_TIMEOUT_EN
        logic [31:0] wcnt;

        // Compared at full width so a narrow counter that saturates below TIMEOUT never fires.
        assign meas_to = !rise && (SAT_W'(cnt) == SAT_W'(TIMEOUT - 1));
        assign arm_to  = !rise && (wcnt == 32'(TIMEOUT - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wcnt <= '0;
            end else if (en && state == ARM && !rise && !arm_to) begin
                wcnt <= wcnt + 32'd1;
            end else begin
                wcnt <= '0;
            end
        end
`else
        assign meas_to = 1'b0;
        assign arm_to  = 1'b0;
`endif

        assign unused_bits = ^{inc.val, acc_shr, TIMEOUT};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
            end else begin
                state <= state_next;
            end
        end

        always_comb begin
            state_next = state;
            if (!en) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:    state_next = ARM;
                    ARM:     if (rise) state_next = MEAS;
                    MEAS:    if (meas_to) state_next = ARM;
                    default: state_next = IDLE;
                endcase
            end
        end

        always_comb begin
            do_arm     = 1'b0;
            do_sample  = 1'b0;
            do_result  = 1'b0;
            do_timeout = 1'b0;
            if (en) begin
                case (state)
                    ARM: begin
                        do_arm     = rise;
                        do_timeout = arm_to;
                    end
                    MEAS: begin
                        do_sample  = rise;
                        do_result  = rise && (nsmp_next == NAVG);
                        do_timeout = meas_to;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                acc      <= '0;
                nsmp     <= '0;
                sat_flag <= 1'b0;
                per_q    <= '0;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
                to_q     <= 1'b0;
            end else begin
                valid_q <= do_result | do_timeout;
                if (!en || state == IDLE) begin
                    cnt      <= '0;
                    acc      <= '0;
                    nsmp     <= '0;
                    sat_flag <= 1'b0;
                end else if (do_arm) begin
                    cnt <= '0;
                end else if (do_sample) begin
                    cnt <= '0;
                    if (do_result) begin
                        acc      <= '0;
                        nsmp     <= '0;
                        sat_flag <= 1'b0;
                        per_q    <= flag_next ? CNT_MAX : acc_shr[CW-1:0];
                        ovf_q    <= flag_next;
                        to_q     <= 1'b0;
                    end else begin
                        acc      <= acc_next;
                        nsmp     <= nsmp_next;
                        sat_flag <= flag_next;
                    end
                end else if (do_timeout) begin
                    cnt      <= '0;
                    acc      <= '0;
                    nsmp     <= '0;
                    sat_flag <= 1'b0;
                    per_q    <= '0;
                    ovf_q    <= 1'b0;
                    to_q     <= 1'b1;
                end else if (state == MEAS) begin
                    cnt <= smp;
                end
            end
        end

        assign period_out[k*CW +: CW] = per_q;
        assign period_valid[k]        = valid_q;
        assign ovf[k]                 = ovf_q;
        assign timeout[k]             = to_q;
    end

endmodule

// File: tb/tb_freq_meter_mc.sv
// tb/tb_freq_meter_mc.sv - directed bench for freq_meter_mc (main 2-channel and narrow 1-channel builds).
module tb_freq_meter_mc;

    localparam int WD = 14;
    localparam int CW = 32;

    typedef struct {
        int cyc;
        int val;
        int o;
        int t;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [WD-1:0] s [3];
    logic [WD-1:0]        threshold;
    logic [1:0]           ch_en;
    logic                 en_s;
    logic [2*WD-1:0]      signal_in;
    logic [2*CW-1:0]      period_out;
    logic [1:0]           period_valid;
    logic [1:0]           ovf;
    logic [1:0]           timeout;
    logic [7:0]           period_s;
    logic                 valid_s;
    logic                 ovf_s;
    logic                 timeout_s;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    ev_t log0[$];
    ev_t log1[$];
    ev_t logs[$];
    int  rise0[$];

    assign signal_in = {s[1], s[0]};

    freq_meter_mc #(.WD(WD), .CH(2), .CW(CW), .AVG_LOG2(2), .TIMEOUT(1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (signal_in),
        .threshold    (threshold),
        .ch_en        (ch_en),
        .period_out   (period_out),
        .period_valid (period_valid),
        .ovf          (ovf),
        .timeout      (timeout)
    );

    freq_meter_mc #(.WD(WD), .CH(1), .CW(8), .AVG_LOG2(0), .TIMEOUT(1000)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (s[2]),
        .threshold    (threshold),
        .ch_en        (en_s),
        .period_out   (period_s),
        .period_valid (valid_s),
        .ovf          (ovf_s),
        .timeout      (timeout_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_valid[0]) log0.push_back('{cyc, int'(period_out[31:0]), int'(ovf[0]), int'(timeout[0])});
        if (period_valid[1]) log1.push_back('{cyc, int'(period_out[63:32]), int'(ovf[1]), int'(timeout[1])});
        if (valid_s)         logs.push_back('{cyc, int'(period_s), int'(ovf_s), int'(timeout_s)});
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_period(input int ch, input int per, input int amp);
        for (int i = 0; i < per; i++) begin
            @(negedge clk);
            if (i == 0 && ch == 0) rise0.push_back(cyc);
            s[ch] = (i < per / 2) ? WD'(amp) : WD'(-amp);
        end
    endtask

    task automatic hold(input int ch, input int n, input int val);
        repeat (n) begin
            @(negedge clk);
            s[ch] = WD'(val);
        end
    endtask

    task automatic noise(input int ch, input int n, input int amp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s[ch] = (((i / 3) % 2) == 0) ? WD'(amp) : WD'(-amp);
        end
    endtask

    initial begin
        s[0] = WD'(-1000);
        s[1] = WD'(-1000);
        s[2] = WD'(-1000);
        threshold = WD'(200);
        ch_en = 2'b00;
        en_s = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_period0", int'(period_out[31:0]), 0);
        check("rst_period1", int'(period_out[63:32]), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_period_s", int'(period_s), 0);
        rst = 1'b0;

        // Square wave period 100, then 99/101/100/104 averaging to 101.
        ch_en[0] = 1'b1;
        hold(0, 20, -1000);
        repeat (8) drive_period(0, 100, 1000);
        drive_period(0, 99, 1000);
        drive_period(0, 101, 1000);
        drive_period(0, 100, 1000);
        drive_period(0, 104, 1000);
        drive_period(0, 100, 1000);
        ch_en[0] = 1'b0;
        check("t1_count", log0.size(), 3);
        check("t1_first", log0[0].val, 100);
        check("t1_ovf", log0[0].o, 0);
        check("t1_latency", log0[0].cyc - rise0[4], 2);
        check("t1_second", log0[1].val, 100);
        check("t1_spacing", log0[1].cyc - log0[0].cyc, 400);
        check("t2_trunc", log0[2].val, 101);
        check("t1_ch1_quiet", log1.size(), 0);

        // Noise inside the hysteresis band, including equality, must not toggle Q.
        ch_en[1] = 1'b1;
        noise(1, 60, 150);
        noise(1, 60, 200);
        check("t3_hyst_quiet", log1.size(), 0);
        threshold = WD'(0);
        repeat (6) drive_period(1, 6, 150);
        check("t3_thr0_count", log1.size(), 1);
        check("t3_thr0_period", log1[0].val, 6);

        // Drop enable mid-average; the next result must only see post-rearm periods.
        threshold = WD'(200);
        repeat (2) drive_period(1, 100, 1000);
        ch_en[1] = 1'b0;
        repeat (3) drive_period(1, 100, 1000);
        check("t4_disabled_quiet", log1.size(), 1);
        ch_en[1] = 1'b1;
        repeat (5) drive_period(1, 40, 1000);
        check("t4_count", log1.size(), 2);
        check("t4_rearm_period", log1[1].val, 40);

        // Narrow counter: saturation boundary at 255/256 and ovf clearing.
        en_s = 1'b1;
        hold(2, 5, -1000);
        drive_period(2, 300, 1000);
        drive_period(2, 255, 1000);
        drive_period(2, 256, 1000);
        drive_period(2, 50, 1000);
        drive_period(2, 50, 1000);
        check("t5_count", logs.size(), 4);
        check("t5_sat_period", logs[0].val, 255);
        check("t5_sat_ovf", logs[0].o, 1);
        check("t5_255_period", logs[1].val, 255);
        check("t5_255_ovf", logs[1].o, 0);
        check("t5_256_period", logs[2].val, 255);
        check("t5_256_ovf", logs[2].o, 1);
        check("t5_clean_period", logs[3].val, 50);
        check("t5_clean_ovf", logs[3].o, 0);

        // DC input on channel 0.
        ch_en[0] = 1'b1;
        hold(0, 1100, -1000);
`ifdef FREQ_METER_TIMEOUT_EN
        check("t6_to_count", log0.size(), 4);
        check("t6_to_period", log0[3].val, 0);
        check("t6_to_flag", log0[3].t, 1);
`else
        check("t6_no_strobe", log0.size(), 3);
        check("t6_hold_period", int'(period_out[31:0]), 101);
        check("t6_timeout_low", int'(timeout), 0);
`endif

        // Asynchronous reset mid-run clears outputs without waiting for a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_period0", int'(period_out[31:0]), 0);
        check("mid_rst_period1", int'(period_out[63:32]), 0);
        check("mid_rst_valid", int'(period_valid), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_timeout", int'(timeout), 0);
        check("mid_rst_period_s", int'(period_s), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
